// File: rtl/monobit_pkg.sv
// Shared types and width helpers for the monobit frequency tester.
// Sums are signed, LOG2_N+2 bits wide; magnitudes are compared unsigned.
package monobit_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam int MAX_LOG2_N = 12;
  localparam int MAX_SUM_W  = MAX_LOG2_N + 2;

  function automatic int sum_w(input int log2_n);
    return log2_n + 2;
  endfunction

  function automatic int th_w(input int log2_n);
    return log2_n + 1;
  endfunction

  // |s| never exceeds N, so the unsigned result always fits in the same width
  function automatic logic [MAX_SUM_W-1:0] abs_sum(input logic signed [MAX_SUM_W-1:0] s);
    return s[MAX_SUM_W-1] ? unsigned'(-s) : unsigned'(s);
  endfunction

endpackage

// File: rtl/monobit_stream_tester_if.sv
// Bit-stream input, result output and run control of the monobit tester.
// master = TRNG source / host side, slave = tester.
interface monobit_stream_tester_if #(
  parameter int LOG2_N = 7,
  parameter int CNT_W  = 8
);
  logic                    enable;
  logic                    bit_in;
  logic                    bit_valid;
  logic                    bit_ready;
  logic [LOG2_N:0]         thresh;
  logic                    res_valid;
  logic                    res_ready;
  logic                    is_random;
  logic signed [LOG2_N+1:0] sum_out;
  logic [CNT_W-1:0]        fail_count;

  modport master (
    output enable, bit_in, bit_valid, thresh, res_ready,
    input  bit_ready, res_valid, is_random, sum_out, fail_count
  );

  modport slave (
    input  enable, bit_in, bit_valid, thresh, res_ready,
    output bit_ready, res_valid, is_random, sum_out, fail_count
  );
endinterface

// File: rtl/monobit_accum.sv
// Block bit counter and signed +/-1 accumulator; self-clears on the last accepted bit.
// sum_next is the running sum including the bit accepted this cycle.
module monobit_accum
  import monobit_pkg::*;
#(
  parameter int LOG2_N = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      accept,
  input  logic                      bit_in,
  output logic                      last,
  output logic signed [LOG2_N+1:0]  sum_next
);
  localparam int SUM_W = sum_w(LOG2_N);

  logic [LOG2_N-1:0]       cnt;
  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] step;

  // +1 for a one, all-ones (-1) for a zero
  assign step     = $signed({{(SUM_W-1){~bit_in}}, 1'b1});
  assign last     = &cnt;
  assign sum_next = accept ? sum + step : sum;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
      sum <= '0;
    end else if (accept) begin
      cnt <= cnt + LOG2_N'(1);
      sum <= last ? '0 : sum_next;
    end
  end

endmodule

// File: rtl/monobit_stream_tester.sv
// Monobit (frequency) test over 2^LOG2_N-bit blocks with handshaked bits and results.
// Result appears 1 cycle after the last bit and is held, with bit_ready low, until res_ready.
module monobit_stream_tester
  import monobit_pkg::*;
#(
  parameter int LOG2_N = 7,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  monobit_stream_tester_if.slave  bus
);
  localparam int SUM_W = sum_w(LOG2_N);

  state_t                  state;
  logic                    bit_ready_q;
  logic                    res_valid_q;
  logic                    is_random_q;
  logic signed [SUM_W-1:0] sum_out_q;
  logic [CNT_W-1:0]        fail_count_q;

  logic                    accept;
  logic                    clear;
  logic                    last;
  logic signed [SUM_W-1:0] sum_next;
  logic signed [MAX_SUM_W-1:0] sum_ext;
  logic [MAX_SUM_W-1:0]    mag;
  logic                    pass;

  assign accept = bus.bit_valid & bit_ready_q;
  // Abort wins over a simultaneous accept, so a dropped enable never leaves a partial sum
  assign clear  = (state == IDLE) | ((state == ACCUM) & ~bus.enable);

  monobit_accum #(.LOG2_N(LOG2_N)) u_accum (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .accept   (accept),
    .bit_in   (bus.bit_in),
    .last     (last),
    .sum_next (sum_next)
  );

  assign sum_ext = MAX_SUM_W'(sum_next);
  assign mag     = abs_sum(sum_ext);
  assign pass    = (mag <= MAX_SUM_W'(bus.thresh));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bit_ready_q  <= 1'b0;
      res_valid_q  <= 1'b0;
      is_random_q  <= 1'b0;
      sum_out_q    <= '0;
      fail_count_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.enable) begin
            state       <= ACCUM;
            bit_ready_q <= 1'b1;
          end
        end
        ACCUM: begin
          if (!bus.enable) begin
            state       <= IDLE;
            bit_ready_q <= 1'b0;
          end else if (accept && last) begin
            state       <= REPORT;
            bit_ready_q <= 1'b0;
            res_valid_q <= 1'b1;
            sum_out_q   <= sum_next;
            is_random_q <= pass;
          end
        end
        REPORT: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            if (!is_random_q && (fail_count_q != '1))
              fail_count_q <= fail_count_q + CNT_W'(1);
            state       <= bus.enable ? ACCUM : IDLE;
            bit_ready_q <= bus.enable;
          end
        end
        default: begin
          state       <= IDLE;
          bit_ready_q <= 1'b0;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bit_ready  = bit_ready_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.is_random  = is_random_q;
  assign bus.sum_out    = sum_out_q;
  assign bus.fail_count = fail_count_q;

endmodule

// File: tb/tb_monobit_stream_tester.sv
// Directed bench: 128-bit tester driven from a vector table, plus hand sequences
// for backpressure, abort, a 4-bit/2-bit-counter instance and mid-block reset.
module tb_monobit_stream_tester;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  monobit_stream_tester_if #(.LOG2_N(7), .CNT_W(8)) if7();
  monobit_stream_tester_if #(.LOG2_N(2), .CNT_W(2)) if2();

  monobit_stream_tester #(.LOG2_N(7), .CNT_W(8)) dut7 (.clk(clk), .rst(rst), .bus(if7.slave));
  monobit_stream_tester #(.LOG2_N(2), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  int checks = 0;
  int errors = 0;
  bit pat [128];

  typedef struct {
    int         ones;
    bit         alt;
    logic [7:0] th_early;
    logic [7:0] th_last;
    int         exp_sum;
    bit         exp_rand;
    int         exp_fail;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic fill(input int ones, input bit alt);
    for (int i = 0; i < 128; i++)
      pat[i] = alt ? (i % 2 == 0) : (i < ones);
  endtask

  // Presents pat[0..n-1]; thresh switches to th_last just before the final bit
  task automatic feed7(input int n, input logic [7:0] th_last);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (if7.bit_ready) begin
        if (i == n - 1) if7.thresh = th_last;
        if7.bit_in    = pat[i];
        if7.bit_valid = 1'b1;
        i++;
      end else begin
        if7.bit_valid = 1'b0;
      end
    end
    if (i < n) chk("feed7_timeout", i, n);
  endtask

  task automatic result7(input string nm, input int exp_sum, input bit exp_rand, input int exp_fail);
    @(negedge clk);
    if7.bit_valid = 1'b0;
    chk({nm, "_res_valid"}, if7.res_valid, 1);
    chk({nm, "_sum"}, if7.sum_out, exp_sum);
    chk({nm, "_is_random"}, if7.is_random, exp_rand);
    if7.res_ready = 1'b1;
    @(negedge clk);
    if7.res_ready = 1'b0;
    chk({nm, "_res_drop"}, if7.res_valid, 0);
    chk({nm, "_fail_count"}, if7.fail_count, exp_fail);
  endtask

  task automatic feed2(input int n);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 200) begin
      @(negedge clk);
      guard++;
      if (if2.bit_ready) begin
        if2.bit_in    = 1'b1;
        if2.bit_valid = 1'b1;
        i++;
      end else begin
        if2.bit_valid = 1'b0;
      end
    end
    if (i < n) chk("feed2_timeout", i, n);
  endtask

  task automatic result2(input string nm, input int exp_fail);
    @(negedge clk);
    if2.bit_valid = 1'b0;
    chk({nm, "_res_valid"}, if2.res_valid, 1);
    chk({nm, "_sum"}, if2.sum_out, 4);
    chk({nm, "_is_random"}, if2.is_random, 0);
    if2.res_ready = 1'b1;
    @(negedge clk);
    if2.res_ready = 1'b0;
    chk({nm, "_fail_count"}, if2.fail_count, exp_fail);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_bit_ready7"}, if7.bit_ready, 0);
    chk({nm, "_res_valid7"}, if7.res_valid, 0);
    chk({nm, "_is_random7"}, if7.is_random, 0);
    chk({nm, "_sum7"}, if7.sum_out, 0);
    chk({nm, "_fail7"}, if7.fail_count, 0);
    chk({nm, "_bit_ready2"}, if2.bit_ready, 0);
    chk({nm, "_res_valid2"}, if2.res_valid, 0);
    chk({nm, "_is_random2"}, if2.is_random, 0);
    chk({nm, "_sum2"}, if2.sum_out, 0);
    chk({nm, "_fail2"}, if2.fail_count, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit stable;
    vecs = '{
      '{128, 1'b0, 8'd23,  8'd23,  128,  1'b0, 1},
      '{0,   1'b1, 8'd0,   8'd0,   0,    1'b1, 1},
      '{76,  1'b0, 8'd0,   8'd24,  24,   1'b1, 1},
      '{76,  1'b0, 8'd255, 8'd23,  24,   1'b0, 2},
      '{52,  1'b0, 8'd24,  8'd24,  -24,  1'b1, 2},
      '{0,   1'b0, 8'd127, 8'd127, -128, 1'b0, 3},
      '{0,   1'b0, 8'd128, 8'd128, -128, 1'b1, 3}
    };

    rst = 1'b1;
    if7.enable = 1'b0; if7.bit_in = 1'b0; if7.bit_valid = 1'b0; if7.thresh = '0; if7.res_ready = 1'b0;
    if2.enable = 1'b0; if2.bit_in = 1'b0; if2.bit_valid = 1'b0; if2.thresh = '0; if2.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    if7.enable = 1'b1;

    for (int v = 0; v < 7; v++) begin
      if7.thresh = vecs[v].th_early;
      fill(vecs[v].ones, vecs[v].alt);
      feed7(128, vecs[v].th_last);
      result7($sformatf("vec%0d", v), vecs[v].exp_sum, vecs[v].exp_rand, vecs[v].exp_fail);
    end

    // Backpressure: result held while ones are offered and refused
    fill(128, 1'b0);
    if7.thresh = 8'd200;
    feed7(128, 8'd200);
    @(negedge clk);
    chk("bp_res_valid", if7.res_valid, 1);
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if7.bit_valid = 1'b1;
      if7.bit_in    = 1'b1;
      @(negedge clk);
      if (!(if7.res_valid === 1'b1 && if7.sum_out === 9'sd128 &&
            if7.is_random === 1'b1 && if7.bit_ready === 1'b0)) stable = 1'b0;
    end
    chk("bp_stable", stable, 1);
    if7.bit_valid = 1'b0;
    if7.res_ready = 1'b1;
    @(negedge clk);
    if7.res_ready = 1'b0;
    chk("bp_fail_count", if7.fail_count, 3);
    chk("bp_bit_ready", if7.bit_ready, 1);
    fill(0, 1'b1);
    if7.thresh = 8'd0;
    feed7(128, 8'd0);
    result7("after_bp", 0, 1'b1, 3);

    // Abort after 60 ones, then a clean all-zero block
    fill(128, 1'b0);
    if7.thresh = 8'd255;
    feed7(60, 8'd255);
    @(negedge clk);
    if7.enable    = 1'b0;
    if7.bit_valid = 1'b1;
    if7.bit_in    = 1'b1;
    stable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (!(if7.res_valid === 1'b0 && if7.bit_ready === 1'b0)) stable = 1'b0;
    end
    chk("abort_idle", stable, 1);
    if7.bit_valid = 1'b0;
    if7.enable    = 1'b1;
    fill(0, 1'b0);
    feed7(128, 8'd255);
    result7("after_abort", -128, 1'b1, 3);

    // Small instance: saturating 2-bit fail counter
    if2.enable = 1'b1;
    if2.thresh = '0;
    for (int k = 0; k < 5; k++) begin
      feed2(4);
      result2($sformatf("sat%0d", k), (k + 1 > 3) ? 3 : k + 1);
    end

    // Reset in the middle of a block
    feed2(2);
    @(negedge clk);
    if2.bit_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk_reset("midrst");
    rst = 1'b0;
    feed2(4);
    result2("post_rst", 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
